lsu_mem_stage: RTL

//  Memory-access stage directly downstream of the ALU. Takes alu_out as the effective address plus the

---
 rtl/lsu_mem_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module      : lsu_mem_stage
// Description : Load/store memory stage. Drives a req/gnt/rvalid data port,
//               aligns store lanes, extends load data, registers writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] store_data,
    input  logic [2:0]       funct3,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t       r_state;
    logic [2:0]   r_funct3;
    logic [1:0]   r_off;
    logic [4:0]   r_rd;
    logic         r_reg_write;

    logic             w_accept;
    logic             w_is_mem;
    logic             w_misalign;
    logic             w_bad_f3;
    logic             w_err;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;

    assign ex_ready = (r_state == ST_IDLE);
    assign w_accept = ex_valid & ex_ready;
    assign w_off    = alu_out[1:0];
    assign w_is_mem = mem_read | mem_write;

    assign w_misalign = ((funct3[1:0] == 2'b01) & alu_out[0])
                      | ((funct3[1:0] == 2'b10) & (|alu_out[1:0]));
    assign w_bad_f3   = (mem_read  & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
                      | (mem_write & (funct3 > 3'b010));
    assign w_err      = (mem_read & mem_write) | (w_is_mem & (w_misalign | w_bad_f3));

    // Lane placement by access size; loads reuse the pattern as read strobes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    assign w_byte = 8'(dmem_rdata >> {r_off, 3'b000});
    assign w_half = 16'(dmem_rdata >> {r_off[1], 4'b0000});

    always_comb begin
        w_load = dmem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= '0;
            wb_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem || w_err) begin
                            wb_valid <= 1'b1;
                            wb_err   <= w_err;
                            wb_we    <= reg_write & ~w_err;
                            wb_rd    <= rd;
                            wb_data  <= alu_out;
                        end else begin
                            r_state     <= ST_REQ;
                            r_funct3    <= funct3;
                            r_off       <= w_off;
                            r_rd        <= rd;
                            r_reg_write <= reg_write & mem_read;
                            dmem_req    <= 1'b1;
                            dmem_we     <= mem_write;
                            dmem_addr   <= {alu_out[WIDTH-1:2], 2'b00};
                            dmem_be     <= w_be;
                            dmem_wdata  <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= 4'b0000;
                        // dmem_we still reflects the op here: low means load.
                        if (dmem_we) begin
                            r_state  <= ST_IDLE;
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_rd    <= r_rd;
                        end else if (dmem_rvalid) begin
                            r_state  <= ST_IDLE;
                            wb_valid <= 1'b1;
                            wb_we    <= r_reg_write;
                            wb_rd    <= r_rd;
                            wb_data  <= w_load;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_state  <= ST_IDLE;
                        wb_valid <= 1'b1;
                        wb_we    <= r_reg_write;
                        wb_rd    <= r_rd;
                        wb_data  <= w_load;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
